aes64_blk_ctrl: RTL and testbench
=================================

Name: aes64_blk_ctrl

Overview:
- Block-level AES-128 controller and initiator on the aes64 request/response interface.
- Accepts one 128-bit block plus a direction bit, fetches round keys from an external key store, and issues the 20 hi/lo round operations to aes64.
- Returns the finished ciphertext or plaintext on a valid/ready output channel.
- Sits between a DMA/streaming front end and the aes64 datapath.

Parameters:
- NROUNDS, 10, number of AES rounds (AES-128 only; fixed value, no other values supported).

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous, active-high reset
- blk_valid  in  1  input block offered
- blk_ready  out  1  controller idle, can accept
- blk_dec  in  1  1 = decrypt (equivalent inverse cipher), 0 = encrypt
- blk_data  in  128  AES block; block byte i at bits [8i+7:8i]
- rk_req  out  1  round-key request
- rk_idx  out  4  round-key index 0..10
- rk_ack  in  1  rk_data valid this cycle
- rk_data  in  128  round key, same byte order as blk_data
- aes_valid  out  1  aes64 request valid
- aes_hi  out  1  aes64 hi select
- aes_mix  out  1  aes64 mix enable
- aes_op_enc  out  1  aes64 encrypt op
- aes_op_dec  out  1  aes64 decrypt op
- aes_rs1  out  64  state[63:0]
- aes_rs2  out  64  state[127:64]
- aes_rd  in  64  aes64 result
- aes_ready  in  1  aes64 result valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  128  result block

Behaviour:
- Reset (g_reset high at a clock edge):
  - FSM goes to IDLE; round counter r = 0.
  - Outputs after reset: blk_ready = 1; rk_req, aes_valid, aes_hi, aes_mix, aes_op_enc, aes_op_dec, out_valid all 0; rk_idx = 0; aes_rs1, aes_rs2, out_data = 0.
  - Reset mid-operation aborts immediately. aes_valid may drop while aes_ready is low; under reset this is permitted. The key store and aes64 are reset alongside.
- Registers: state[127:0], tmp_lo[63:0], dec, r[3:0].
- IDLE:
  - blk_ready = 1.
  - On blk_valid && blk_ready: state <= blk_data, dec <= blk_dec, r <= 0, go to RK.
- RK:
  - rk_req = 1; rk_idx = dec ? 10 - r : r. rk_req and rk_idx are held until rk_ack.
  - On rk_ack with r == 0: state <= state ^ rk_data.
  - On rk_ack with r != 0: state <= {aes_rd_hi_latched, tmp_lo} ^ rk_data.
  - If r == 10, go to DONE. Otherwise r <= r + 1 and go to OP_LO.
  - rk_ack while rk_req is low is ignored.
- OP_LO:
  - aes_valid = 1, aes_hi = 0, aes_op_enc = !dec, aes_op_dec = dec, aes_mix = (r != 10).
  - rs1/rs2 are driven from state, which is unchanged throughout the round.
  - All request outputs are held stable while aes_valid && !aes_ready.
  - On aes_ready: tmp_lo <= aes_rd, go to OP_HI.
- OP_HI:
  - Same request with aes_hi = 1.
  - On aes_ready: latch aes_rd as the hi half, go to RK.
- DONE:
  - out_valid = 1, out_data = state; held stable until out_ready.
  - On out_ready: go to IDLE.
  - blk_ready is asserted only in IDLE, so a new block is accepted no earlier than the cycle after the out handshake.
- Decrypt:
  - Keys are fetched 10, 9, …, 0.
  - The key store supplies InvMixColumns-transformed keys for indices 1..9; this block does not transform keys.
- aes_ready is sampled only while aes_valid is high; aes_ready = 1 in the same cycle as aes_valid completes that op.
- Latency with rk_ack and aes_ready tied high:
  - Accept cycle is T; out_valid first high at T+32.
  - Each cycle of rk_ack or aes_ready delay adds exactly one cycle.
- aes64 ops other than enc/dec are never issued; the integrator ties aes64 op_imix/op_ks1/op_ks2 low.

Test Plan:
- FIPS-197 encrypt:
  - Stimulus: blk_dec = 0, blk_data = 128'h340737e0a29831318d305a88a8f64332, key store loaded with the expanded key for 2b7e151628aed2a6abf7158809cf4f3c (rk0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b).
  - Response: out_data = 128'h320b6a19978511dcfb09dc021d842539; out_valid rises at T+32; rk_idx sequence 0..10.
- FIPS-197 decrypt:
  - Stimulus: blk_dec = 1, ciphertext from the encrypt case, key store supplying rk10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0, InvMixColumns keys 9..1, then rk0.
  - Response: out_data = the plaintext; rk_idx sequence 10..0.
- Backpressure:
  - Stimulus: random 0–5 cycle stalls on aes_ready, rk_ack and out_ready.
  - Response: same result; aes_*/rk_idx/out_data stable during every stall; latency = 32 + total stall cycles.
- Reset mid-operation:
  - Stimulus: g_reset asserted for 1 cycle during OP_HI of round 5, then a fresh encrypt.
  - Response: next cycle all outputs at reset values, blk_ready = 1; the fresh encrypt produces the correct FIPS-197 ciphertext.
- Busy/back-to-back:
  - Stimulus: blk_valid held high continuously with a new block.
  - Response: blk_ready = 0 from T+1 until the cycle after the out handshake; exactly one acceptance per block; two consecutive blocks both correct.

Source files
------------

// File: rtl/aes64_blk_ctrl.sv
// AES-128 block controller: sequences key fetches and aes64 hi/lo round ops
// for one 128-bit block at a time, returning the result on a valid/ready channel.
module aes64_blk_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         blk_dec,
    input  logic [127:0] blk_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_ack,
    input  logic [127:0] rk_data,
    output logic         aes_valid,
    output logic         aes_hi,
    output logic         aes_mix,
    output logic         aes_op_enc,
    output logic         aes_op_dec,
    output logic [63:0]  aes_rs1,
    output logic [63:0]  aes_rs2,
    input  logic [63:0]  aes_rd,
    input  logic         aes_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RK    = 3'd1;
    localparam logic [2:0] S_OP_LO = 3'd2;
    localparam logic [2:0] S_OP_HI = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    logic [2:0]   fsm;
    logic [127:0] state;
    logic [63:0]  tmp_lo;
    logic [63:0]  tmp_hi;
    logic         dec;
    logic [3:0]   r;
    logic         in_op;

    assign in_op      = (fsm == S_OP_LO) || (fsm == S_OP_HI);

    assign blk_ready  = (fsm == S_IDLE);
    assign rk_req     = (fsm == S_RK);
    assign rk_idx     = rk_req ? (dec ? (LAST_ROUND - r) : r) : 4'd0;

    // state is frozen for the whole round, so both halves see the same operands
    assign aes_valid  = in_op;
    assign aes_hi     = (fsm == S_OP_HI);
    assign aes_mix    = in_op && (r != LAST_ROUND);
    assign aes_op_enc = in_op && !dec;
    assign aes_op_dec = in_op && dec;
    assign aes_rs1    = in_op ? state[63:0]   : 64'd0;
    assign aes_rs2    = in_op ? state[127:64] : 64'd0;

    assign out_valid  = (fsm == S_DONE);
    assign out_data   = (fsm == S_DONE) ? state : 128'd0;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            fsm    <= S_IDLE;
            state  <= 128'd0;
            tmp_lo <= 64'd0;
            tmp_hi <= 64'd0;
            dec    <= 1'b0;
            r      <= 4'd0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (blk_valid) begin
                        state <= blk_data;
                        dec   <= blk_dec;
                        r     <= 4'd0;
                        fsm   <= S_RK;
                    end
                end
                S_RK: begin
                    if (rk_ack) begin
                        // round 0 is the initial whitening; later rounds fold in the aes64 result
                        state <= ((r == 4'd0) ? state : {tmp_hi, tmp_lo}) ^ rk_data;
                        if (r == LAST_ROUND) begin
                            fsm <= S_DONE;
                        end else begin
                            r   <= r + 4'd1;
                            fsm <= S_OP_LO;
                        end
                    end
                end
                S_OP_LO: begin
                    if (aes_ready) begin
                        tmp_lo <= aes_rd;
                        fsm    <= S_OP_HI;
                    end
                end
                S_OP_HI: begin
                    if (aes_ready) begin
                        tmp_hi <= aes_rd;
                        fsm    <= S_RK;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes64_blk_ctrl.sv
// Bench for aes64_blk_ctrl: models the key store and aes64 unit, and checks
// results against a plain FIPS-197 cipher / inverse cipher kept here.
module tb_aes64_blk_ctrl;

    logic         g_clk = 1'b0;
    logic         g_reset;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_dec;
    logic [127:0] blk_data;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_ack;
    logic [127:0] rk_data;
    logic         aes_valid;
    logic         aes_hi;
    logic         aes_mix;
    logic         aes_op_enc;
    logic         aes_op_dec;
    logic [63:0]  aes_rs1;
    logic [63:0]  aes_rs2;
    logic [63:0]  aes_rd;
    logic         aes_ready;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    aes64_blk_ctrl dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_dec(blk_dec), .blk_data(blk_data),
        .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_data(rk_data),
        .aes_valid(aes_valid), .aes_hi(aes_hi), .aes_mix(aes_mix),
        .aes_op_enc(aes_op_enc), .aes_op_dec(aes_op_dec),
        .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_rd(aes_rd), .aes_ready(aes_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 g_clk = ~g_clk;

    localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FIPS_PT  = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] FIPS_CT  = 128'h320b6a19978511dcfb09dc021d842539;

    int           compared   = 0;
    int           mismatched = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] rkeys [11];
    logic         cur_dec;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // byte i of a block is row i%4, column i/4
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) begin
                int src;
                src = inv ? (col - row + 4) % 4 : (col + row) % 4;
                o[8*(row + 4*col) +: 8] = s[8*(row + 4*src) +: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int col = 0; col < 4; col++)
            for (int k = 0; k < 4; k++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - k + 4) % 4], s[8*(j + 4*col) +: 8]);
                o[8*(k + 4*col) +: 8] = acc;
            end
        return o;
    endfunction

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox[t[8*b +: 8]];
                t[7:0] ^= rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rkeys[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkeys[0];
        for (int k = 1; k <= 10; k++) begin
            s = shift_rows(sub_bytes(s, 0), 0);
            if (k != 10) s = mix_columns(s, 0);
            s ^= rkeys[k];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rkeys[10];
        for (int k = 9; k >= 0; k--) begin
            s = sub_bytes(shift_rows(s, 1), 1);
            s ^= rkeys[k];
            if (k != 0) s = mix_columns(s, 1);
        end
        return s;
    endfunction

    // aes64 unit: one full round on {rs2,rs1}, returning the selected half
    function automatic logic [63:0] aes64_model(input logic [63:0] rs1, input logic [63:0] rs2,
                                                input bit hi, input bit mix, input bit dec);
        logic [127:0] s;
        s = {rs2, rs1};
        if (dec) begin
            s = sub_bytes(shift_rows(s, 1), 1);
            if (mix) s = mix_columns(s, 1);
        end else begin
            s = shift_rows(sub_bytes(s, 0), 0);
            if (mix) s = mix_columns(s, 0);
        end
        return hi ? s[127:64] : s[63:0];
    endfunction

    // key store hands out InvMixColumns keys for the middle rounds when decrypting
    function automatic logic [127:0] key_for(input logic [3:0] idx);
        if (idx > 4'd10) return 128'd0;
        if (cur_dec && idx != 4'd0 && idx != 4'd10) return mix_columns(rkeys[idx], 1);
        return rkeys[idx];
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctl"},
                    {blk_ready, rk_req, aes_valid, aes_hi, aes_mix, aes_op_enc, aes_op_dec, out_valid, rk_idx},
                    {8'b1000_0000, 4'd0});
        checkOutput({tag, "_rs"}, {aes_rs2, aes_rs1}, 128'd0);
        checkOutput({tag, "_out"}, out_data, 128'd0);
    endtask

    task automatic applyStimulus(input logic [127:0] din, input logic d, input logic [127:0] exp,
                                 input int max_stall, input bit keep_valid, input int abort_op);
        int          cyc, stalls, k_n, op_n, rk_wait, aes_wait, out_wait, budget;
        bit          rk_pend, aes_pend, out_pend, finished;
        logic [3:0]  held_idx;
        logic [3:0]  held_ctl;
        logic [3:0]  exp_ctl;
        logic [127:0] held_rs, round_rs, held_out;
        stalls = 0; k_n = 0; op_n = 0; rk_wait = 0; aes_wait = 0; out_wait = 0;
        rk_pend = 0; aes_pend = 0; out_pend = 0; finished = 0;
        held_idx = 4'd0; held_ctl = 4'd0; held_rs = '0; round_rs = '0; held_out = '0;
        cur_dec   = d;
        blk_data  = din;
        blk_dec   = d;
        blk_valid = 1'b1;
        budget    = 0;
        while (!blk_ready && budget < 100) begin
            @(posedge g_clk); #1;
            budget++;
        end
        if (!blk_ready) begin
            checkOutput("accept_timeout", {127'd0, blk_ready}, 128'd1);
            blk_valid = 1'b0;
            return;
        end
        @(posedge g_clk); #1;
        if (!keep_valid) blk_valid = 1'b0;
        cyc = 1;
        while (!finished && cyc <= 400) begin
            checkOutput("busy", {127'd0, blk_ready}, 128'd0);

            rk_ack  = (max_stall > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            rk_data = rand128();
            if (rk_req) begin
                if (!rk_pend) begin
                    checkOutput("rk_idx", {124'd0, rk_idx}, d ? 128'(10 - k_n) : 128'(k_n));
                    rk_pend  = 1;
                    held_idx = rk_idx;
                    rk_wait  = int'($urandom_range(max_stall, 0));
                    stalls  += rk_wait;
                end else begin
                    checkOutput("rk_idx_hold", {124'd0, rk_idx}, {124'd0, held_idx});
                end
                if (rk_wait == 0) begin
                    rk_ack  = 1'b1;
                    rk_data = key_for(held_idx);
                    rk_pend = 0;
                    k_n++;
                end else begin
                    rk_ack = 1'b0;
                    rk_wait--;
                end
            end

            aes_ready = (max_stall > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            aes_rd    = {$urandom(), $urandom()};
            if (aes_valid) begin
                if (!aes_pend) begin
                    exp_ctl = {1'(op_n % 2), (op_n / 2) != 9, !d, d};
                    checkOutput("aes_ctl", {124'd0, aes_hi, aes_mix, aes_op_enc, aes_op_dec}, {124'd0, exp_ctl});
                    if (aes_hi) checkOutput("round_rs", {aes_rs2, aes_rs1}, round_rs);
                    else        round_rs = {aes_rs2, aes_rs1};
                    aes_pend = 1;
                    held_ctl = {aes_hi, aes_mix, aes_op_enc, aes_op_dec};
                    held_rs  = {aes_rs2, aes_rs1};
                    aes_wait = int'($urandom_range(max_stall, 0));
                    stalls  += aes_wait;
                    if (op_n == abort_op) begin
                        g_reset = 1'b1; rk_ack = 1'b0; aes_ready = 1'b0; out_ready = 1'b0; blk_valid = 1'b0;
                        @(posedge g_clk); #1;
                        g_reset = 1'b0;
                        checkResetOutputs("abort");
                        return;
                    end
                end else begin
                    checkOutput("aes_ctl_hold", {124'd0, aes_hi, aes_mix, aes_op_enc, aes_op_dec}, {124'd0, held_ctl});
                    checkOutput("aes_rs_hold", {aes_rs2, aes_rs1}, held_rs);
                end
                if (aes_wait == 0) begin
                    aes_ready = 1'b1;
                    aes_rd    = aes64_model(held_rs[63:0], held_rs[127:64], held_ctl[3], held_ctl[2], d);
                    aes_pend  = 0;
                    op_n++;
                end else begin
                    aes_ready = 1'b0;
                    aes_wait--;
                end
            end

            out_ready = 1'b0;
            if (out_valid) begin
                if (!out_pend) begin
                    checkOutput("latency", 128'(cyc), 128'(32 + stalls));
                    checkOutput("out_data", out_data, exp);
                    out_pend = 1;
                    held_out = out_data;
                    out_wait = int'($urandom_range(max_stall, 0));
                end else begin
                    checkOutput("out_hold", out_data, held_out);
                end
                if (out_wait == 0) begin
                    out_ready = 1'b1;
                    finished  = 1;
                end else begin
                    out_wait--;
                end
            end

            @(posedge g_clk); #1;
            cyc++;
        end
        rk_ack = 1'b0; aes_ready = 1'b0; out_ready = 1'b0;
        if (!finished) begin
            checkOutput("timeout", {127'd0, out_valid}, 128'd1);
            blk_valid = 1'b0;
            g_reset = 1'b1;
            @(posedge g_clk); #1;
            g_reset = 1'b0;
            return;
        end
        checkOutput("ready_after", {127'd0, blk_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] b1, b2, key, data;
        logic [7:0]   inv, s;
        logic         d;
        g_reset = 1'b1; blk_valid = 1'b0; blk_dec = 1'b0; blk_data = '0;
        rk_ack = 1'b0; rk_data = '0; aes_rd = '0; aes_ready = 1'b0; out_ready = 1'b0;
        cur_dec = 1'b0;

        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[i]  = s;
            isbox[s] = 8'(i);
        end

        repeat (2) @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        checkResetOutputs("reset");

        expandKey(FIPS_KEY);
        $display("[TB] FIPS-197 encrypt / decrypt");
        applyStimulus(FIPS_PT, 1'b0, FIPS_CT, 0, 0, -1);
        applyStimulus(FIPS_CT, 1'b1, FIPS_PT, 0, 0, -1);

        $display("[TB] backpressure");
        applyStimulus(FIPS_PT, 1'b0, FIPS_CT, 5, 0, -1);
        applyStimulus(FIPS_CT, 1'b1, FIPS_PT, 5, 0, -1);

        $display("[TB] reset during round 5 hi op");
        applyStimulus(FIPS_PT, 1'b0, FIPS_CT, 2, 0, 9);
        applyStimulus(FIPS_PT, 1'b0, FIPS_CT, 0, 0, -1);

        $display("[TB] back-to-back with blk_valid held");
        b1 = rand128();
        b2 = rand128();
        applyStimulus(b1, 1'b0, aes_encrypt(b1), 0, 1, -1);
        applyStimulus(b2, 1'b1, aes_decrypt(b2), 3, 1, -1);
        blk_valid = 1'b0;

        $display("[TB] random keys and blocks");
        for (int n = 0; n < 6; n++) begin
            key = rand128();
            expandKey(key);
            d    = 1'($urandom_range(1, 0));
            data = rand128();
            applyStimulus(data, d, d ? aes_decrypt(data) : aes_encrypt(data), int'($urandom_range(5, 0)), 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
